pos_decode_32bit: RTL and testbench
===================================

POS_DECODE_32BIT -- requirements
Module: pos_decode_32bit

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8: width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: input_pos is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-006 SHALL have port input_pos, input, 6: MSB position code; 0 = all-zero word, 1..32 = bit (code-1) is the MSB, 33..63 = illegal.
REQ-007 SHALL have port out_valid, output, 1: output_num/out_err valid.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts output this cycle.
REQ-009 SHALL have port output_num, output, 32: decoded one-hot word.
REQ-010 SHALL have port out_err, output, 1: the current output came from an illegal code.
REQ-011 SHALL have port err_count, output, ERR_CNT_W: count of illegal codes accepted.

Function
REQ-012 SHALL accept an input (transfer) on any posedge where in_valid && in_ready.
REQ-013 SHALL use a 2-stage pipeline: S1 registers input_pos; S2 registers the decoded output_num/out_err; latency = 2 cycles from transfer to out_valid with no stall.
REQ-014 SHALL decode code 0 to output_num = 32'h0000_0000, out_err = 0.
REQ-015 SHALL decode code k in 1..32 to output_num with only bit k-1 set, out_err = 0 (k=1 -> 32'h1, k=32 -> 32'h8000_0000).
REQ-016 SHALL decode codes 33..63 to output_num = 0, out_err = 1.
REQ-017 SHALL advance S2 when S2 is empty or out_ready=1; S1 SHALL advance into S2 under the same condition.
REQ-018 SHALL drive in_ready = !S1_valid || S2 advancing (full throughput: one transfer per cycle when out_ready held 1).
REQ-019 SHALL hold output_num, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL not lose or duplicate any transfer under arbitrary in_valid/out_ready patterns; order preserved.
REQ-021 SHALL increment err_count by 1 when an illegal code enters S2, saturating at all-ones (no wrap).
REQ-022 SHALL, on simultaneous S1 load and S1 drain in one cycle, keep S1_valid = 1 with the new code.
REQ-023 SHALL make in_ready a function of registered state and out_ready only (no combinational path from in_valid or input_pos).

Reset
REQ-024 SHALL, while rst=1, force out_valid=0, output_num=0, out_err=0, err_count=0, S1_valid=0, in_ready=1.
REQ-025 SHALL discard any in-flight data when rst asserts mid-operation; no output after reset release until a new transfer completes.
REQ-026 SHALL ignore in_valid during rst=1.

Configuration
REQ-027 SHALL, when macro THERMO_MASK_EN is defined, add output port output_mask, 32 bits, registered in S2 alongside output_num: code k in 1..32 -> bits [k-1:0] set; code 0 or illegal -> 0; reset value 0; held under stall like output_num.
REQ-028 SHALL, when THERMO_MASK_EN is not defined, omit output_mask and its logic entirely; all other behaviour identical.

Verification
REQ-029 SHALL verify: out_ready=1, codes 0,1,17,32 back-to-back -> output_num 0, 32'h1, 32'h0001_0000, 32'h8000_0000 on consecutive cycles starting 2 cycles after first transfer, out_err=0.
REQ-030 SHALL verify: code 40 then code 63 -> output_num=0, out_err=1 both; err_count=2.
REQ-031 SHALL verify: out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 transfers accepted, in_ready=0 afterwards, output held; on out_ready=1 all codes emitted in order.
REQ-032 SHALL verify: ERR_CNT_W=2, five illegal codes -> err_count sticks at 3.
REQ-033 SHALL verify: rst pulsed with both stages full -> out_valid=0, err_count=0 asynchronously, in_ready=1; next code 5 -> output_num=32'h10.
REQ-034 SHALL verify (THERMO_MASK_EN defined): code 4 -> output_mask=32'h0000_000F; code 32 -> 32'hFFFF_FFFF; code 0 -> 0.

Source files
------------

// File: rtl/pos_decode_32bit.sv
// rtl/pos_decode_32bit.sv - two-stage MSB-position to one-hot decoder with valid/ready flow control
// Optional output_mask (thermometer code) enabled by defining THERMO_MASK_EN.
module pos_decode_32bit #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           input_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          output_num,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef THERMO_MASK_EN
    ,
    output logic [31:0]          output_mask
`endif
);

    logic                 s1_valid_q, s1_valid_d;
    logic [5:0]           s1_code_q, s1_code_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          num_q, num_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic        s2_adv;
    logic        xfer_in;
    logic        code_illegal;
    logic [31:0] dec_num;

    // S2 drains when empty or consumed; S1 moves into S2 on the same condition.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign xfer_in  = in_valid && in_ready;

    assign code_illegal = (s1_code_q > 6'd32);
    assign dec_num      = (s1_code_q == 6'd0 || code_illegal) ? 32'h0
                                                              : (32'h1 << (s1_code_q - 6'd1));

`ifdef THERMO_MASK_EN
    logic [31:0] mask_q, mask_d;
    logic [31:0] dec_mask;

    // Shifting all-ones by 32 yields zero, so code 32 inverts to a full mask.
    assign dec_mask = code_illegal ? 32'h0 : ~(32'hFFFF_FFFF << s1_code_q);

    always_comb begin
        mask_d = mask_q;
        if (s2_adv && s1_valid_q) begin
            mask_d = dec_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 32'h0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign output_mask = mask_q;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        if (xfer_in) begin
            s1_valid_d = 1'b1;
            s1_code_d  = input_pos;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        num_d      = num_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                num_d = dec_num;
                err_d = code_illegal;
                if (code_illegal && cnt_q != {ERR_CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= 6'd0;
            s2_valid_q <= 1'b0;
            num_q      <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s2_valid_q <= s2_valid_d;
            num_q      <= num_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign output_num = num_q;
    assign out_err    = err_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_pos_decode_32bit.sv
// tb/tb_pos_decode_32bit.sv - self-checking bench for pos_decode_32bit (define THERMO_MASK_EN to cover output_mask)
module tb_pos_decode_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  input_pos = 6'd0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] output_num;
    logic [7:0]  err_count;
    logic        in_ready_s, out_valid_s, out_err_s;
    logic [31:0] output_num_s;
    logic [1:0]  err_count_s;
`ifdef THERMO_MASK_EN
    logic [31:0] output_mask, output_mask_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pos_decode_32bit #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_pos(input_pos), .out_valid(out_valid), .out_ready(out_ready),
        .output_num(output_num), .out_err(out_err), .err_count(err_count)
`ifdef THERMO_MASK_EN
        , .output_mask(output_mask)
`endif
    );

    pos_decode_32bit #(.ERR_CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .input_pos(input_pos), .out_valid(out_valid_s), .out_ready(out_ready),
        .output_num(output_num_s), .out_err(out_err_s), .err_count(err_count_s)
`ifdef THERMO_MASK_EN
        , .output_mask(output_mask_s)
`endif
    );

    function automatic logic [31:0] ref_num(input logic [5:0] code);
        int k = int'(code);
        if (k >= 1 && k <= 32) return 32'(64'd2 ** (k - 1));
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [5:0] code);
        int k = int'(code);
        if (k >= 1 && k <= 32) return 32'(64'd2 ** k - 64'd1);
        return 32'h0;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; input_pos = 6'd0;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; input_pos = 6'd45; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (output_num !== 32'h0) begin errors++; $display("FAIL rst_output_num got=%h exp=0", output_num); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got=%0b exp=0", out_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
`ifdef THERMO_MASK_EN
        checks++; if (output_mask !== 32'h0) begin errors++; $display("FAIL rst_output_mask got=%h exp=0", output_mask); end
`endif
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_out_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  codes [4];
        logic [31:0] exp   [4];
        codes = '{6'd0, 6'd1, 6'd17, 6'd32};
        exp   = '{32'h0, 32'h1, 32'h0001_0000, 32'h8000_0000};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            in_valid  = (n < 4);
            input_pos = (n < 4) ? codes[n] : 6'd0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", n, in_ready); end
            if (n >= 2) begin
                checks++; if (out_valid !== 1'b1 || output_num !== exp[n-2] || out_err !== 1'b0) begin
                    errors++; $display("FAIL b2b_out cyc=%0d got v=%0b num=%h err=%0b exp v=1 num=%h err=0", n, out_valid, output_num, out_err, exp[n-2]);
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid cyc=%0d got=%0b exp=0", n, out_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] codes [2];
        codes = '{6'd40, 6'd63};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid  = (n < 2);
            input_pos = (n < 2) ? codes[n] : 6'd0;
            if (n >= 2) begin
                checks++; if (out_valid !== 1'b1 || output_num !== 32'h0 || out_err !== 1'b1) begin
                    errors++; $display("FAIL illegal_out code=%0d got v=%0b num=%h err=%0b exp v=1 num=0 err=1", codes[n-2], out_valid, output_num, out_err);
                end
            end
            @(negedge clk);
        end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL illegal_err_count got=%0d exp=2", err_count); end
    endtask

    task automatic test_stall();
        logic [5:0] c [5];
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 5; i++) c[i] = 6'($urandom_range(1, 32));
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1; input_pos = c[idx];
            #1;
            if (n >= 2) begin
                checks++; if (out_valid !== 1'b1 || output_num !== ref_num(c[0])) begin
                    errors++; $display("FAIL stall_hold cyc=%0d got v=%0b num=%h exp v=1 num=%h", n, out_valid, output_num, ref_num(c[0]));
                end
            end
            if (in_ready) idx++;
            @(negedge clk);
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (out_valid) begin
                checks++; if (got >= 2 || output_num !== ref_num(c[got])) begin
                    errors++; $display("FAIL stall_drain idx=%0d got num=%h exp num=%h", got, output_num, (got < 2) ? ref_num(c[got]) : 32'h0);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 2) begin errors++; $display("FAIL stall_drain_count got=%0d exp=2", got); end
    endtask

    task automatic test_err_sat();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1; input_pos = 6'($urandom_range(33, 63));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL sat_err_count_w8 got=%0d exp=5", err_count); end
        checks++; if (err_count_s !== 2'd3) begin errors++; $display("FAIL sat_err_count_w2 got=%0d exp=3", err_count_s); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; input_pos = (n == 0) ? 6'd40 : 6'd50;
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1 || err_count !== 8'd1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_pre got v=%0b cnt=%0d rdy=%0b exp v=1 cnt=1 rdy=0", out_valid, err_count, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midrst_err_count got=%0d exp=0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost cyc=%0d got=%0b exp=0", n, out_valid); end
        end
        in_valid = 1'b1; input_pos = 6'd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || output_num !== 32'h10 || out_err !== 1'b0) begin
            errors++; $display("FAIL midrst_code5 got v=%0b num=%h err=%0b exp v=1 num=00000010 err=0", out_valid, output_num, out_err);
        end
    endtask

`ifdef THERMO_MASK_EN
    task automatic test_mask();
        logic [5:0]  codes [3];
        logic [31:0] exp   [3];
        codes = '{6'd4, 6'd32, 6'd0};
        exp   = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h0};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_valid  = (n < 3);
            input_pos = (n < 3) ? codes[n] : 6'd0;
            if (n >= 2) begin
                checks++; if (out_valid !== 1'b1 || output_mask !== exp[n-2]) begin
                    errors++; $display("FAIL mask code=%0d got v=%0b mask=%h exp v=1 mask=%h", codes[n-2], out_valid, output_mask, exp[n-2]);
                end
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_random(input int ncyc);
        logic [5:0] sb [$];
        int ill = 0;
        logic exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < ncyc + 10; cyc++) begin
            if (cyc < ncyc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                input_pos = 6'($urandom_range(0, 63));
                out_ready = ((cyc % 64) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            exp_rdy = (sb.size() < 2) || out_ready;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_rdy); end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc=%0d got v=1 exp v=0", cyc);
                end else if (output_num !== ref_num(sb[0]) || out_err !== (sb[0] > 6'd32)) begin
                    errors++; $display("FAIL rand_out cyc=%0d code=%0d got num=%h err=%0b exp num=%h err=%0b", cyc, sb[0], output_num, out_err, ref_num(sb[0]), sb[0] > 6'd32);
                end
`ifdef THERMO_MASK_EN
                if (sb.size() != 0) begin
                    checks++; if (output_mask !== ref_mask(sb[0])) begin errors++; $display("FAIL rand_mask cyc=%0d got=%h exp=%h", cyc, output_mask, ref_mask(sb[0])); end
                end
`endif
                if (out_ready && sb.size() != 0) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(input_pos);
                if (input_pos > 6'd32) ill++;
            end
            @(negedge clk);
        end
        checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain left=%0d got v=%0b exp left=0 v=0", sb.size(), out_valid); end
        checks++; if (int'(err_count) != ((ill > 255) ? 255 : ill)) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", err_count, (ill > 255) ? 255 : ill); end
        checks++; if (int'(err_count_s) != ((ill > 3) ? 3 : ill)) begin errors++; $display("FAIL rand_err_count_w2 got=%0d exp=%0d", err_count_s, (ill > 3) ? 3 : ill); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_err_sat();
        test_reset_midflight();
`ifdef THERMO_MASK_EN
        test_mask();
`endif
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
